// File: rtl/parity_pkg.sv
// Shared types and constants for the serial even-parity receive path.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DATA   = 2'b01,
        PARITY = 2'b10
    } state_t;

    localparam logic PARITY_EVEN = 1'b0;

    // Width needed to count 0..data_w accepted data bits.
    function automatic int unsigned cnt_width(input int unsigned data_w);
        return (data_w < 1) ? 1 : $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/serial_even_parity_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/serial_even_parity_checker.sv
// Deserialises an MSB-first frame plus even-parity bit, flags parity errors and counts them.
module serial_even_parity_checker
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W    = 3,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sin_valid,
    input  logic                 sin,
    input  logic                 start,
    input  logic                 clr_err,
    output logic [DATA_W-1:0]    data_out,
    output logic                 out_valid,
    output logic                 parity_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned      CNT_W = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W);

    state_t              state, state_n;
    logic [DATA_W-1:0]   shreg, shreg_n;
    logic [CNT_W-1:0]    bit_cnt, cnt_n;
    logic                run_par, par_n;
    logic [DATA_W-1:0]   data_n;
    logic                err_n;
    logic                valid_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            run_par    <= 1'b0;
            data_out   <= '0;
            parity_err <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bit_cnt    <= cnt_n;
            run_par    <= par_n;
            data_out   <= data_n;
            parity_err <= err_n;
            out_valid  <= valid_n;
            busy       <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = bit_cnt;
        par_n   = run_par;
        data_n  = data_out;
        err_n   = parity_err;
        valid_n = 1'b0;
        if (sin_valid) begin
            // A qualified start restarts from any state, dropping a partial frame.
            if (start) begin
                shreg_n = DATA_W'(sin);
                cnt_n   = CNT_W'(1);
                par_n   = sin;
                state_n = (DATA_W == 1) ? PARITY : DATA;
            end else begin
                case (state)
                    DATA: begin
                        shreg_n = (shreg << 1) | DATA_W'(sin);
                        par_n   = run_par ^ sin;
                        cnt_n   = bit_cnt + CNT_W'(1);
                        if (cnt_n == LAST) begin
                            state_n = PARITY;
                        end
                    end
                    PARITY: begin
                        data_n  = shreg;
                        err_n   = ((run_par ^ sin) != PARITY_EVEN);
                        valid_n = 1'b1;
                        state_n = IDLE;
                        shreg_n = '0;
                        cnt_n   = '0;
                        par_n   = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    sat_counter #(
        .WIDTH(ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (valid_n & err_n),
        .clr   (clr_err),
        .count (err_count)
    );

endmodule

// File: tb/tb_serial_even_parity_checker.sv
// Randomised and directed bench for serial_even_parity_checker against a frame-level model.
module tb_serial_even_parity_checker;

    localparam int unsigned DW = 3;
    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sin_valid = 1'b0;
    logic          sin = 1'b0;
    logic          start = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic          parity_err;
    logic          busy;
    logic [CW-1:0] err_count;

    int errors = 0;
    int checks = 0;

    // Frame-level reference: bits collected since the last qualified start.
    int unsigned  frame_q[$];
    bit           in_frame;
    int unsigned  m_data, m_cnt;
    bit           m_valid, m_err, m_busy;

    serial_even_parity_checker #(
        .DATA_W    (DW),
        .ERR_CNT_W (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin_valid  (sin_valid),
        .sin        (sin),
        .start      (start),
        .clr_err    (clr_err),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .parity_err (parity_err),
        .busy       (busy),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"},  32'(out_valid),  32'(m_valid));
        check({tag, ".data_out"},   32'(data_out),   m_data);
        check({tag, ".parity_err"}, 32'(parity_err), 32'(m_err));
        check({tag, ".busy"},       32'(busy),       32'(m_busy));
        check({tag, ".err_count"},  32'(err_count),  m_cnt);
    endtask

    task automatic model_reset();
        frame_q.delete();
        in_frame = 0;
        m_data = 0; m_cnt = 0; m_valid = 0; m_err = 0; m_busy = 0;
    endtask

    task automatic model_step(input bit v, input bit s, input bit st, input bit clr);
        int unsigned word, ones;
        m_valid = 0;
        if (v) begin
            if (st) begin
                frame_q.delete();
                frame_q.push_back(s);
                in_frame = 1;
            end else if (in_frame) begin
                frame_q.push_back(s);
            end
            if (in_frame && frame_q.size() == DW + 1) begin
                word = 0;
                ones = 0;
                for (int i = 0; i < DW; i++) word = word * 2 + frame_q[i];
                foreach (frame_q[i]) ones += frame_q[i];
                m_data  = word;
                m_err   = (ones % 2) != 0;
                m_valid = 1;
                in_frame = 0;
                frame_q.delete();
            end
        end
        if (clr) m_cnt = 0;
        else if (m_valid && m_err && m_cnt < (1 << CW) - 1) m_cnt++;
        m_busy = in_frame;
    endtask

    task automatic step(input bit v, input bit s, input bit st, input bit clr, input string tag);
        @(negedge clk);
        sin_valid = v; sin = s; start = st; clr_err = clr;
        model_step(v, s, st, clr);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic send_frame(input logic [DW-1:0] w, input bit p, input int gaps,
                              input bit clr_on_par, input string tag);
        logic [DW-1:0] word;
        word = w;
        for (int i = DW - 1; i >= 0; i--) begin
            step(1, word[i], i == DW - 1, 0, tag);
            for (int g = 0; g < gaps; g++) step(0, 0, 0, 0, tag);
        end
        step(1, p, 0, clr_on_par, tag);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst_n = 0; sin_valid = 0; start = 0; clr_err = 0;
        model_reset();
        #1 check_all({tag, ".async"});
        repeat (2) @(posedge clk);
        #1 check_all({tag, ".held"});
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        apply_reset("por");

        // Reset mid-frame then a clean frame
        step(1, 1, 1, 0, "pre_rst");
        step(1, 0, 0, 0, "pre_rst");
        apply_reset("mid_rst");
        send_frame(3'b101, 0, 0, 0, "after_rst");
        step(0, 0, 0, 0, "after_rst.idle");

        send_frame(3'b101, 0, 0, 0, "good");
        send_frame(3'b011, 1, 0, 0, "bad");
        send_frame(3'b111, 1, 0, 0, "b2b");
        step(0, 0, 0, 0, "b2b.idle");

        send_frame(3'b110, 0, 3, 0, "gaps");
        step(0, 0, 0, 0, "gaps.idle");

        // Abort: partial frame then restart
        step(1, 1, 1, 0, "abort");
        step(1, 0, 0, 0, "abort");
        send_frame(3'b111, 1, 0, 0, "abort");
        step(0, 0, 1, 0, "start_no_valid");

        // Saturation then clear coinciding with an error latch
        for (int k = 0; k < 4; k++) send_frame(3'b001, 0, 0, 0, "sat");
        step(0, 0, 0, 0, "sat.idle");
        send_frame(3'b001, 0, 0, 1, "clr_vs_inc");
        step(0, 0, 0, 0, "clr.idle");

        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0, "rand");
            if (n == 300) apply_reset("rand_rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
